// File: rtl/fill_station_ctrl.sv
// Bottle filling station controller: it debounces the IR bottle sensor and sequences the
// conveyor and pump through transport, settle, fill and exit phases, with fault latching.
module fill_station_ctrl #(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd500_000,
    parameter logic [31:0] SETTLE_CYCLES   = 32'd25_000_000,
    parameter logic [31:0] FILL_CYCLES     = 32'd200_000_000,
    parameter logic [31:0] EXIT_TIMEOUT    = 32'd250_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ir_punjenje,
    input  logic        start,
    input  logic        fault_clr,
    output logic        traka,
    output logic        pumpa,
    output logic        punjenje_gotovo,
    output logic        greska,
    output logic [15:0] broj_flasa
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRANSPORT = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_FILL      = 3'd3,
        ST_EXIT      = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    // True when one more cycle completes a span of 'limit' cycles; a limit of 0 also counts as reached.
    function automatic logic span_done(input logic [31:0] cnt, input logic [31:0] limit);
        logic [32:0] next_cnt;
        next_cnt  = {1'b0, cnt} + 33'd1;
        span_done = (next_cnt >= {1'b0, limit});
    endfunction

    logic        sync1_r;
    logic        sync2_r;
    logic        present_r;
    logic        raw_present_s;
    logic [31:0] deb_cnt_r;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] timer_r;
    logic        done_s;
    logic        traka_s;
    logic        pumpa_s;
    logic        greska_s;

    logic        traka_r;
    logic        pumpa_r;
    logic        gotovo_r;
    logic        greska_r;
    logic [15:0] count_r;

    // The sensor is active-low, so the synchronized level is inverted to give "bottle present".
    assign raw_present_s = ~sync2_r;

    // Two-flop synchronizer for the asynchronous IR input; it idles high (no bottle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= ir_punjenje;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_r <= 32'd0;
            present_r <= 1'b0;
        end else if (raw_present_s == present_r) begin
            deb_cnt_r <= 32'd0;
            present_r <= present_r;
        end else if (span_done(deb_cnt_r, DEBOUNCE_CYCLES)) begin
            deb_cnt_r <= 32'd0;
            present_r <= raw_present_s;
        end else begin
            deb_cnt_r <= deb_cnt_r + 32'd1;
            present_r <= present_r;
        end
    end

    // Next-state logic; bottle loss is checked ahead of timer expiry in every timed phase.
    always_comb begin
        next_state_s = state_r;
        done_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_TRANSPORT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_TRANSPORT: begin
                if (present_r) begin
                    next_state_s = ST_SETTLE;
                end else if (!start) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_TRANSPORT;
                end
            end
            ST_SETTLE: begin
                if (!present_r) begin
                    next_state_s = ST_TRANSPORT;
                end else if (span_done(timer_r, SETTLE_CYCLES)) begin
                    next_state_s = ST_FILL;
                end else begin
                    next_state_s = ST_SETTLE;
                end
            end
            ST_FILL: begin
                if (!present_r) begin
                    next_state_s = ST_FAULT;
                end else if (span_done(timer_r, FILL_CYCLES)) begin
                    next_state_s = ST_EXIT;
                    done_s       = 1'b1;
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            ST_EXIT: begin
                if (!present_r) begin
                    if (start) begin
                        next_state_s = ST_TRANSPORT;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else if (span_done(timer_r, EXIT_TIMEOUT)) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_EXIT;
                end
            end
            ST_FAULT: begin
                if (fault_clr && !start) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_FAULT;
                end
            end
            default: begin
                next_state_s = ST_FAULT;
            end
        endcase
    end

    // Output levels are decoded from the next state so that the registered outputs track the state register.
    always_comb begin
        traka_s  = 1'b0;
        pumpa_s  = 1'b0;
        greska_s = 1'b0;
        case (next_state_s)
            ST_TRANSPORT: traka_s  = 1'b1;
            ST_EXIT:      traka_s  = 1'b1;
            ST_FILL:      pumpa_s  = 1'b1;
            ST_FAULT:     greska_s = 1'b1;
            default: begin
                traka_s  = 1'b0;
                pumpa_s  = 1'b0;
                greska_s = 1'b0;
            end
        endcase
    end

    // State register and the shared phase timer, which restarts on every state change and saturates otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            timer_r <= 32'd0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s != state_r) begin
                timer_r <= 32'd0;
            end else if (timer_r != 32'hFFFF_FFFF) begin
                timer_r <= timer_r + 32'd1;
            end else begin
                timer_r <= timer_r;
            end
        end
    end

    // Output registers; the fill counter wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            traka_r  <= 1'b0;
            pumpa_r  <= 1'b0;
            gotovo_r <= 1'b0;
            greska_r <= 1'b0;
            count_r  <= 16'd0;
        end else begin
            traka_r  <= traka_s;
            pumpa_r  <= pumpa_s;
            gotovo_r <= done_s;
            greska_r <= greska_s;
            if (done_s) begin
                count_r <= count_r + 16'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign traka           = traka_r;
    assign pumpa           = pumpa_r;
    assign punjenje_gotovo = gotovo_r;
    assign greska          = greska_r;
    assign broj_flasa      = count_r;

endmodule

// File: doc/fill_station_ctrl.md
FILL_STATION_CTRL -- requirements
Module: fill_station_ctrl

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 32'd500_000, the number of consecutive stable cycles required to accept an IR level change (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 32'd25_000_000, the conveyor-stopped settle time before filling (0.5 s).
REQ-003 The block SHALL have parameter FILL_CYCLES, default 32'd200_000_000, the pump-on time per bottle (4 s).
REQ-004 The block SHALL have parameter EXIT_TIMEOUT, default 32'd250_000_000, the maximum time allowed for a filled bottle to leave the sensor (5 s).
Ports (name, direction, width, meaning):
REQ-005 clk, input, 1, 50 MHz system clock; all state SHALL change on its rising edge only.
REQ-006 rst_n, input, 1, asynchronous active-low reset.
REQ-007 ir_punjenje, input, 1, raw IR sensor, asynchronous; 0 = bottle present.
REQ-008 start, input, 1, line enable; 1 = run.
REQ-009 fault_clr, input, 1, fault acknowledge; honoured only while start = 0.
REQ-010 traka, output, 1, conveyor motor enable.
REQ-011 pumpa, output, 1, filling pump/valve enable.
REQ-012 punjenje_gotovo, output, 1, single-cycle pulse on fill completion; this pulse is the handoff to the capping stage.
REQ-013 greska, output, 1, fault flag.
REQ-014 broj_flasa, output, 16, count of completed fills.

Function
REQ-015 ir_punjenje SHALL pass through a 2-flop synchronizer; the debounced "present" signal SHALL change only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles, and any intermediate glitch SHALL restart that count.
REQ-016 The FSM SHALL have the states IDLE, TRANSPORT, SETTLE, FILL, EXIT and FAULT, with one shared 32-bit cycle timer that clears on every state entry.
REQ-017 IDLE: traka = 0 and pumpa = 0; start = 1 moves to TRANSPORT.
REQ-018 TRANSPORT: traka = 1; present = 1 moves to SETTLE; start = 0 moves to IDLE; present takes priority if both occur in the same cycle.
REQ-019 SETTLE: traka = 0; after the timer reaches SETTLE_CYCLES-1, move to FILL; present = 0 before then moves back to TRANSPORT.
REQ-020 FILL: pumpa = 1 and traka = 0; after FILL_CYCLES cycles, move to EXIT, assert punjenje_gotovo for exactly one cycle, and increment broj_flasa.
REQ-021 broj_flasa SHALL wrap from 16'hFFFF to 0.
REQ-022 FILL: present = 0 before completion SHALL move to FAULT; pumpa SHALL drop on the next edge, with no pulse and no count increment.
REQ-023 start = 0 during SETTLE or FILL SHALL NOT abort; the bottle completes, and the decision is taken at EXIT.
REQ-024 EXIT: traka = 1 and pumpa = 0; present = 0 moves to TRANSPORT if start = 1, otherwise to IDLE; the timer reaching EXIT_TIMEOUT with present still 1 moves to FAULT.
REQ-025 FAULT: traka = 0, pumpa = 0, greska = 1; exit to IDLE only when fault_clr = 1 and start = 0 in the same cycle; start = 1 keeps the block in FAULT.
REQ-026 pumpa and traka SHALL never be 1 in the same cycle.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 rst_n = 0 SHALL immediately and asynchronously force: state = IDLE, traka = 0, pumpa = 0, punjenje_gotovo = 0, greska = 0, broj_flasa = 0, timer = 0, debounce counter = 0, synchronizer flops = 1, present = 0.
REQ-029 Reset asserted mid-FILL SHALL drop pumpa without waiting for a clock edge.
REQ-030 After rst_n deasserts, the block SHALL resume from IDLE with no pulse.

Verification (parameters overridden to DEBOUNCE = 4, SETTLE = 8, FILL = 16, EXIT_TIMEOUT = 32)
REQ-031 Nominal cycle: start = 1, then ir = 0 held, then ir = 1 after gotovo -> traka 1 -> 0; pumpa high for exactly 16 cycles; one gotovo pulse; broj_flasa = 1; traka = 1 in EXIT; return to TRANSPORT.
REQ-032 Glitch: a 3-cycle ir = 0 pulse in TRANSPORT -> no SETTLE entry; traka stays 1.
REQ-033 Bottle removed mid-FILL: ir = 1 at fill cycle 10 -> pumpa low after debounce; greska = 1; count unchanged; fault_clr with start = 1 is ignored; fault_clr with start = 0 -> IDLE and greska = 0.
REQ-034 Exit jam: ir held 0 after fill -> FAULT exactly 32 cycles after EXIT entry; traka = 0.
REQ-035 start dropped mid-FILL -> fill completes with gotovo pulse, EXIT, then IDLE once ir = 1.
REQ-036 Async reset pulse mid-FILL -> pumpa = 0 before the next edge; all outputs at their reset values; broj_flasa preset to 16'hFFFF wraps to 0 after one fill.
